// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 24-bit memory port between instruction fetch (IF, read-only)
//   and the memory-access stage (MA, load/store). MA wins ties so the
//   pipeline drains first; a saturating starvation counter lets IF win a tie
//   once it has waited STARVE_LIMIT cycles. Only one transaction is in flight
//   at a time, and a response timeout aborts a transaction that memory never
//   acknowledges.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_req_in / if_addr_in       IF request (held until grant) and address
//   if_gnt_out                   one-cycle IF grant pulse
//   if_rdata_out / if_valid_out  IF read data, one-cycle completion pulse
//   ma_req_in / ma_we_in         MA request (held until grant), 1 = store
//   ma_addr_in / ma_wdata_in     MA address and store data
//   ma_gnt_out                   one-cycle MA grant pulse
//   ma_rdata_out / ma_valid_out  MA load data, one-cycle completion pulse
//   mem_req_out                  memory request, held until ack or timeout
//   mem_we_out / mem_addr_out    latched write enable and address
//   mem_wdata_out                latched write data (0 for IF)
//   mem_ack_in / mem_rdata_in    memory completion and read data
//   busy_out                     1 while a transaction is outstanding
//   err_out                      one-cycle pulse on timeout abort
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,    // 1..15
   parameter int unsigned TIMEOUT      = 255   // 1..255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_in,
   input  logic [23:0] if_addr_in,
   output logic        if_gnt_out,
   output logic [23:0] if_rdata_out,
   output logic        if_valid_out,
   input  logic        ma_req_in,
   input  logic        ma_we_in,
   input  logic [23:0] ma_addr_in,
   input  logic [23:0] ma_wdata_in,
   output logic        ma_gnt_out,
   output logic [23:0] ma_rdata_out,
   output logic        ma_valid_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [23:0] mem_addr_out,
   output logic [23:0] mem_wdata_out,
   input  logic        mem_ack_in,
   input  logic [23:0] mem_rdata_in,
   output logic        busy_out,
   output logic        err_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_MA = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   // Timeout fires at the end of the TIMEOUT-th busy cycle, i.e. when the
   // count of already-elapsed busy cycles equals TIMEOUT-1.
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [3:0]  starve_cnt;
   logic [7:0]  tmo_cnt;
   logic        grant_if;
   logic        grant_ma;
   logic        done_ack;
   logic        done_tmo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant_if   = 1'b0;
      grant_ma   = 1'b0;
      done_ack   = 1'b0;
      done_tmo   = 1'b0;
      unique case (state)
         IDLE: begin
            if (if_req_in && (!ma_req_in || starve_cnt == STARVE_MAX)) begin
               grant_if   = 1'b1;
               state_next = BUSY_IF;
            end else if (ma_req_in) begin
               grant_ma   = 1'b1;
               state_next = BUSY_MA;
            end
         end
         BUSY_IF, BUSY_MA: begin
            // An ack on the timeout cycle still counts as a normal completion.
            if (mem_ack_in) begin
               done_ack   = 1'b1;
               state_next = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               done_tmo   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_gnt_out    <= 1'b0;
         ma_gnt_out    <= 1'b0;
         if_valid_out  <= 1'b0;
         ma_valid_out  <= 1'b0;
         if_rdata_out  <= '0;
         ma_rdata_out  <= '0;
         mem_req_out   <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         busy_out      <= 1'b0;
         err_out       <= 1'b0;
         starve_cnt    <= '0;
         tmo_cnt       <= '0;
      end else begin
         if_gnt_out   <= grant_if;
         ma_gnt_out   <= grant_ma;
         if_valid_out <= (state == BUSY_IF) && (done_ack || done_tmo);
         ma_valid_out <= (state == BUSY_MA) && (done_ack || done_tmo);
         err_out      <= done_tmo;
         mem_req_out  <= (state_next != IDLE);
         busy_out     <= (state_next != IDLE);

         // Winner's request is latched at grant and held for the transaction.
         if (grant_if) begin
            mem_we_out    <= 1'b0;
            mem_addr_out  <= if_addr_in;
            mem_wdata_out <= '0;
         end else if (grant_ma) begin
            mem_we_out    <= ma_we_in;
            mem_addr_out  <= ma_addr_in;
            mem_wdata_out <= ma_wdata_in;
         end

         if (grant_if || grant_ma) begin
            tmo_cnt <= '0;
         end else if (state != IDLE && !done_ack && !done_tmo) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end

         if (state == BUSY_IF) begin
            if (done_ack) begin
               if_rdata_out <= mem_rdata_in;
            end else if (done_tmo) begin
               if_rdata_out <= '0;
            end
         end

         if (state == BUSY_MA) begin
            if (done_ack) begin
               if (!mem_we_out) begin
                  ma_rdata_out <= mem_rdata_in;
               end
            end else if (done_tmo) begin
               ma_rdata_out <= '0;
            end
         end

         if (grant_if) begin
            starve_cnt <= '0;
         end else if (if_req_in && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (STARVE_LIMIT = 4, TIMEOUT = 8).
//   A transaction-level reference model tracks who owns the port, how many
//   busy cycles have elapsed, the IF wait count and the last read data.
//   Directed sequences cover reset, IF read, MA store, tie/starvation and
//   timeout; a randomized phase follows with random request traffic and
//   per-transaction memory latencies (including no-ack timeouts).
module tb_mem_port_arbiter;

   localparam int unsigned STARVE_LIMIT = 4;
   localparam int unsigned TIMEOUT      = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [23:0] if_addr = '0;
   logic        ma_req = 1'b0;
   logic        ma_we = 1'b0;
   logic [23:0] ma_addr = '0;
   logic [23:0] ma_wdata = '0;
   logic        mem_ack = 1'b0;
   logic [23:0] mem_rdata = '0;

   logic        if_gnt_out, if_valid_out, ma_gnt_out, ma_valid_out;
   logic [23:0] if_rdata_out, ma_rdata_out;
   logic        mem_req_out, mem_we_out, busy_out, err_out;
   logic [23:0] mem_addr_out, mem_wdata_out;

   mem_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req_in     (if_req),
      .if_addr_in    (if_addr),
      .if_gnt_out    (if_gnt_out),
      .if_rdata_out  (if_rdata_out),
      .if_valid_out  (if_valid_out),
      .ma_req_in     (ma_req),
      .ma_we_in      (ma_we),
      .ma_addr_in    (ma_addr),
      .ma_wdata_in   (ma_wdata),
      .ma_gnt_out    (ma_gnt_out),
      .ma_rdata_out  (ma_rdata_out),
      .ma_valid_out  (ma_valid_out),
      .mem_req_out   (mem_req_out),
      .mem_we_out    (mem_we_out),
      .mem_addr_out  (mem_addr_out),
      .mem_wdata_out (mem_wdata_out),
      .mem_ack_in    (mem_ack),
      .mem_rdata_in  (mem_rdata),
      .busy_out      (busy_out),
      .err_out       (err_out)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int          m_owner = 0;      // 0 = nobody, 1 = IF, 2 = MA
   int          m_elapsed = 0;    // busy cycles finished without completion
   int          m_starve = 0;
   logic        m_we = 1'b0;
   logic [23:0] m_addr = '0;
   logic [23:0] m_wdata = '0;
   logic [23:0] m_if_rdata = '0;
   logic [23:0] m_ma_rdata = '0;
   bit          e_gnt_if, e_gnt_ma, e_val_if, e_val_ma, e_err;

   // Memory behaviour: ack in the busy cycle whose index equals ack_lat
   int          ack_lat = 0;
   int          force_lat = -2;   // -2 = random latency
   bit          directed = 1'b0;
   logic [23:0] dir_rdata = '0;

   task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int pick_lat();
      int r;
      if (force_lat != -2) return force_lat;
      r = int'($urandom_range(0, 9));
      if (r <= 3) return 0;
      if (r <= 5) return 1;
      if (r == 6) return 2;
      if (r == 7) return int'(TIMEOUT) - 1;
      if (r == 8) return -1;
      return 3;
   endfunction

   task automatic model_reset();
      m_owner = 0; m_elapsed = 0; m_starve = 0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_ma_rdata = '0;
      e_gnt_if = 0; e_gnt_ma = 0; e_val_if = 0; e_val_ma = 0; e_err = 0;
   endtask

   // Applies the arbitration rules to the inputs seen at the edge just taken.
   task automatic model_edge();
      bit take_if, take_ma;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_gnt_if = 0; e_gnt_ma = 0; e_val_if = 0; e_val_ma = 0; e_err = 0;
      take_if = (m_owner == 0) && if_req && (!ma_req || m_starve == int'(STARVE_LIMIT));
      take_ma = (m_owner == 0) && ma_req && !take_if;
      if (m_owner != 0) begin
         if (mem_ack) begin
            if (m_owner == 1) begin
               m_if_rdata = mem_rdata; e_val_if = 1;
            end else begin
               if (!m_we) m_ma_rdata = mem_rdata;
               e_val_ma = 1;
            end
            m_owner = 0;
         end else if (m_elapsed + 1 == int'(TIMEOUT)) begin
            e_err = 1;
            if (m_owner == 1) begin m_if_rdata = '0; e_val_if = 1; end
            else begin m_ma_rdata = '0; e_val_ma = 1; end
            m_owner = 0;
         end else begin
            m_elapsed++;
         end
      end else if (take_if) begin
         m_owner = 1; m_elapsed = 0; e_gnt_if = 1;
         m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
         ack_lat = pick_lat();
      end else if (take_ma) begin
         m_owner = 2; m_elapsed = 0; e_gnt_ma = 1;
         m_we = ma_we; m_addr = ma_addr; m_wdata = ma_wdata;
         ack_lat = pick_lat();
      end
      if (take_if) m_starve = 0;
      else if (if_req && m_starve < int'(STARVE_LIMIT)) m_starve++;
   endtask

   task automatic compare();
      bit busy;
      busy = (m_owner != 0);
      check_eq("ctl",
         {40'd0, if_gnt_out, ma_gnt_out, if_valid_out, ma_valid_out, err_out,
          mem_req_out, busy_out, (busy ? mem_we_out : 1'b0)},
         {40'd0, e_gnt_if, e_gnt_ma, e_val_if, e_val_ma, e_err,
          busy, busy, (busy ? m_we : 1'b0)});
      check_eq("rdata", {if_rdata_out, ma_rdata_out}, {m_if_rdata, m_ma_rdata});
      if (busy) check_eq("mem_bus", {mem_addr_out, mem_wdata_out}, {m_addr, m_wdata});
   endtask

   task automatic drive();
      if (!directed) begin
         if (e_gnt_if) begin
            if_req = ($urandom_range(0, 2) != 0); if_addr = 24'($urandom);
         end else if (!if_req) begin
            if_req = ($urandom_range(0, 1) == 1); if_addr = 24'($urandom);
         end
         if (e_gnt_ma) begin
            ma_req = ($urandom_range(0, 2) != 0); ma_we = 1'($urandom);
            ma_addr = 24'($urandom); ma_wdata = 24'($urandom);
         end else if (!ma_req) begin
            ma_req = ($urandom_range(0, 1) == 1); ma_we = 1'($urandom);
            ma_addr = 24'($urandom); ma_wdata = 24'($urandom);
         end
      end
      mem_rdata = directed ? dir_rdata : 24'($urandom);
      mem_ack = (m_owner != 0) ? (m_elapsed == ack_lat) : ($urandom_range(0, 3) == 0);
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      int n;
      int n_ma;
      bit got;
      bit saw_err;
      bit saw_valid;

      model_reset();

      // Reset with random inputs
      directed = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      check_eq("rst_bus", {mem_addr_out, mem_wdata_out}, 48'd0);
      rst_n = 1'b1;

      // IF read
      directed = 1'b1; force_lat = 1; dir_rdata = 24'hABCDEF;
      if_req = 1'b1; if_addr = 24'h000100; ma_req = 1'b0;
      cycle();
      check_eq("if_gnt", {47'd0, if_gnt_out}, 48'd1);
      check_eq("if_addr", {23'd0, mem_we_out, mem_addr_out}, {24'd0, 24'h000100});
      if_req = 1'b0; if_addr = 24'hFFFFFF;
      n = 0; got = 0;
      for (int i = 0; i < 10 && !got; i++) begin cycle(); n++; got = if_valid_out; end
      check_eq("if_read_lat", 48'(n), 48'd2);
      check_eq("if_read_data", {24'd0, if_rdata_out}, {24'd0, 24'hABCDEF});
      cycle();

      // MA store, inputs change right after grant
      force_lat = 2; dir_rdata = 24'h777777;
      ma_req = 1'b1; ma_we = 1'b1; ma_addr = 24'h00F000; ma_wdata = 24'h123456;
      cycle();
      check_eq("ma_gnt", {47'd0, ma_gnt_out}, 48'd1);
      ma_req = 1'b0; ma_we = 1'b0; ma_addr = 24'h000000; ma_wdata = 24'hFFFFFF;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         cycle();
         if (mem_req_out)
            check_eq("ma_st_bus", {mem_addr_out, mem_wdata_out}, {24'h00F000, 24'h123456});
         got = ma_valid_out;
      end
      check_eq("ma_st_valid", {47'd0, got}, 48'd1);
      check_eq("ma_st_rdata", {24'd0, ma_rdata_out}, 48'd0);
      cycle();

      // Tie and starvation: two rounds, second proves the wait count cleared
      force_lat = 0; if_req = 1'b1; ma_req = 1'b1; ma_we = 1'b0;
      for (int r = 0; r < 2; r++) begin
         n_ma = 0; got = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (ma_gnt_out) n_ma++;
            got = if_gnt_out;
         end
         check_eq("starve_if_win", {47'd0, got}, 48'd1);
         check_eq("starve_ma_wins", 48'(n_ma), 48'd2);
      end
      if_req = 1'b0; ma_req = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // MA load to give ma_rdata a nonzero value
      force_lat = 0; dir_rdata = 24'h5A5A5A;
      ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000010;
      cycle(); ma_req = 1'b0;
      cycle();
      check_eq("ma_ld_data", {24'd0, ma_rdata_out}, {24'd0, 24'h5A5A5A});
      cycle();

      // Timeout with IF waiting
      force_lat = -1;
      ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000020;
      cycle(); ma_req = 1'b0; if_req = 1'b1; if_addr = 24'h000222;
      n = 0; saw_valid = 0; saw_err = 0;
      for (int i = 0; i < 20 && !saw_valid; i++) begin
         cycle(); n++; saw_valid = ma_valid_out; saw_err = err_out;
      end
      check_eq("tmo_cycles", 48'(n), 48'(TIMEOUT));
      check_eq("tmo_err", {47'd0, saw_err}, 48'd1);
      check_eq("tmo_rdata", {24'd0, ma_rdata_out}, 48'd0);
      force_lat = 0;
      got = 0;
      for (int i = 0; i < 3 && !got; i++) begin cycle(); got = if_gnt_out; end
      check_eq("tmo_if_served", {47'd0, got}, 48'd1);
      if_req = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Ack on the last allowed cycle wins over timeout
      force_lat = int'(TIMEOUT) - 1; dir_rdata = 24'h0C0FFE;
      ma_req = 1'b1; ma_we = 1'b0;
      cycle(); ma_req = 1'b0;
      n = 0; saw_valid = 0; saw_err = 0;
      for (int i = 0; i < 20 && !saw_valid; i++) begin
         cycle(); n++; saw_valid = ma_valid_out; saw_err = err_out;
      end
      check_eq("late_ack_cycles", 48'(n), 48'(TIMEOUT));
      check_eq("late_ack_err", {47'd0, saw_err}, 48'd0);
      check_eq("late_ack_data", {24'd0, ma_rdata_out}, {24'd0, 24'h0C0FFE});
      cycle();

      // Asynchronous reset while in BUSY_MA
      force_lat = -1;
      ma_req = 1'b1; ma_we = 1'b0;
      cycle(); ma_req = 1'b0;
      cycle();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async", {46'd0, mem_req_out, busy_out}, 48'd0);
      model_reset();
      cycle(); cycle();
      rst_n = 1'b1;
      saw_valid = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(); if (ma_valid_out || err_out) saw_valid = 1;
      end
      check_eq("rst_no_pulse", {47'd0, saw_valid}, 48'd0);

      // Randomized traffic
      directed = 1'b0; force_lat = -2;
      for (int i = 0; i < 3000; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
